// File: rtl/mmio_console_pkg.sv
// Shared register map for the console/test peripheral: word offsets within
// the window and bit positions inside STATUS.
package mmio_console_pkg;

  localparam logic [7:0] OFS_STATUS     = 8'h00;
  localparam logic [7:0] OFS_TXDATA     = 8'h04;
  localparam logic [7:0] OFS_EXIT       = 8'h08;
  localparam logic [7:0] OFS_CYCLE_LO   = 8'h0C;
  localparam logic [7:0] OFS_CYCLE_HI   = 8'h10;
  localparam logic [7:0] OFS_INSTRET_LO = 8'h14;
  localparam logic [7:0] OFS_INSTRET_HI = 8'h18;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_DONE     = 3;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Show-ahead synchronous FIFO. A push that meets a full FIFO is accepted only
// when a pop frees a slot in the same cycle; otherwise it is dropped and
// reported on push_drop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;
  assign head_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Console/test peripheral: address decoder, TX byte FIFO, exit latch, and
// 64-bit cycle/instret counters with lo-then-hi atomic read shadows.
// Read data is registered so the SoC mux can treat it like RAM.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_wdata,
  input  logic        retire,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] exit_code
);

  logic        hit_now;
  logic [7:0]  ofs;
  logic        wr_en;
  logic        rd_en;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_drop;
  logic        overflow_reg;
  logic        done_reg;
  logic [31:0] exit_code_reg;
  logic [63:0] cycle_reg;
  logic [63:0] instret_reg;
  logic [31:0] cyc_shadow_reg;
  logic [31:0] ins_shadow_reg;
  logic        cyc_snap_reg;
  logic        ins_snap_reg;
  logic        hit_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;

  assign hit_now = (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign ofs     = mem_addr[7:0];
  assign wr_en   = hit_now && (|mem_write);
  assign rd_en   = hit_now && !(|mem_write);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en && (ofs == OFS_TXDATA)),
    .push_data (mem_wdata[7:0]),
    .pop       (tx_valid && tx_ready),
    .head_data (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (fifo_drop)
  );

  assign tx_valid  = !fifo_empty;
  assign hit       = hit_reg;
  assign rdata     = rdata_reg;
  assign done      = done_reg;
  assign exit_code = exit_code_reg;

  // Overflow is sticky; a dropped push outranks a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                            overflow_reg <= 1'b0;
    else if (fifo_drop)                                      overflow_reg <= 1'b1;
    else if (wr_en && ofs == OFS_STATUS && mem_wdata[ST_OVERFLOW]) overflow_reg <= 1'b0;
  end

  // EXIT write latches the code; done stays set until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_reg      <= 1'b0;
      exit_code_reg <= '0;
    end else if (wr_en && ofs == OFS_EXIT) begin
      done_reg      <= 1'b1;
      exit_code_reg <= mem_wdata;
    end
  end

  // Cycle counter: firmware word write wins, the other half holds; frozen once done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             cycle_reg <= '0;
    else if (wr_en && ofs == OFS_CYCLE_LO)    cycle_reg[31:0]  <= mem_wdata;
    else if (wr_en && ofs == OFS_CYCLE_HI)    cycle_reg[63:32] <= mem_wdata;
    else if (!done_reg)                       cycle_reg <= cycle_reg + 64'd1;
  end

  // Retired-instruction counter, same write/freeze rules as the cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             instret_reg <= '0;
    else if (wr_en && ofs == OFS_INSTRET_LO)  instret_reg[31:0]  <= mem_wdata;
    else if (wr_en && ofs == OFS_INSTRET_HI)  instret_reg[63:32] <= mem_wdata;
    else if (!done_reg && retire)             instret_reg <= instret_reg + 64'd1;
  end

  // A lo read captures the hi word; the following hi read consumes the capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_shadow_reg <= '0;
      ins_shadow_reg <= '0;
      cyc_snap_reg   <= 1'b0;
      ins_snap_reg   <= 1'b0;
    end else if (rd_en) begin
      case (ofs)
        OFS_CYCLE_LO:   begin cyc_shadow_reg <= cycle_reg[63:32];   cyc_snap_reg <= 1'b1; end
        OFS_CYCLE_HI:   cyc_snap_reg <= 1'b0;
        OFS_INSTRET_LO: begin ins_shadow_reg <= instret_reg[63:32]; ins_snap_reg <= 1'b1; end
        OFS_INSTRET_HI: ins_snap_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  // Read mux over the register map; unmapped offsets read as zero.
  always_comb begin
    rdata_next = '0;
    case (ofs)
      OFS_STATUS: begin
        rdata_next[ST_EMPTY]    = fifo_empty;
        rdata_next[ST_FULL]     = fifo_full;
        rdata_next[ST_OVERFLOW] = overflow_reg;
        rdata_next[ST_DONE]     = done_reg;
      end
      OFS_CYCLE_LO:   rdata_next = cycle_reg[31:0];
      OFS_CYCLE_HI:   rdata_next = cyc_snap_reg ? cyc_shadow_reg : cycle_reg[63:32];
      OFS_INSTRET_LO: rdata_next = instret_reg[31:0];
      OFS_INSTRET_HI: rdata_next = ins_snap_reg ? ins_shadow_reg : instret_reg[63:32];
      default:        rdata_next = '0;
    endcase
  end

  // One-cycle read latency: hit and data registered from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      hit_reg   <= hit_now;
      rdata_reg <= hit_now ? rdata_next : 32'h0;
    end
  end

endmodule
